// File: rtl/spi_mem_ctrl_pkg.sv
// spi_mem_ctrl_pkg: shared op/state types, SPI SRAM command constants and frame builder (optional SPI_MEM_FAST_READ_EN)
package spi_mem_ctrl_pkg;
  typedef enum logic [1:0] {MEM_NOP = 2'd0, MEM_READ = 2'd1, MEM_WRITE = 2'd2} mem_ctrl_op_e;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} spi_mem_state_e;
  localparam logic [7:0] SPI_CMD_READ      = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE     = 8'h02;
  localparam logic [7:0] SPI_CMD_FAST_READ = 8'h0B;
  localparam logic [5:0] SPI_LEN_WRITE     = 6'd32;
`ifdef SPI_MEM_FAST_READ_EN
  localparam int         SPI_FRAME_BITS    = 40;
  localparam logic [5:0] SPI_LEN_READ      = 6'd40;
  // Fast read appends 8 dummy zero bits; frames are left-aligned so the MSB always leads
  function automatic logic [SPI_FRAME_BITS-1:0] build_frame(input logic rd, input logic [15:0] a, input logic [7:0] d);
    return rd ? {SPI_CMD_FAST_READ, a, 16'h0000} : {SPI_CMD_WRITE, a, d, 8'h00};
  endfunction
`else
  localparam int         SPI_FRAME_BITS    = 32;
  localparam logic [5:0] SPI_LEN_READ      = 6'd32;
  function automatic logic [SPI_FRAME_BITS-1:0] build_frame(input logic rd, input logic [15:0] a, input logic [7:0] d);
    return rd ? {SPI_CMD_READ, a, 8'h00} : {SPI_CMD_WRITE, a, d};
  endfunction
`endif
endpackage

// File: rtl/spi_mem_ctrl_shift.sv
// spi_mem_ctrl_shift: frame shift register, bit counter and two-phase sck generator (one setup cycle, then 2 cycles per bit)
module spi_mem_ctrl_shift
  import spi_mem_ctrl_pkg::*;
(
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_load,
  input  logic [SPI_FRAME_BITS-1:0] i_frame,
  input  logic [5:0]                i_len,
  input  logic                      i_miso,
  output logic                      o_last_bit,
  output logic                      o_sck,
  output logic                      o_mosi,
  output logic [7:0]                o_rx
);
  logic [SPI_FRAME_BITS-1:0] r_sr;
  logic [5:0]                r_cnt;
  logic [5:0]                r_len;
  logic [7:0]                r_rx;
  logic                      r_run;
  logic                      r_setup;
  logic                      r_ph;
  logic                      r_sck;
  assign o_last_bit = r_run & ~r_setup & r_ph & (r_cnt == r_len - 6'd1);
  assign o_rx       = {r_rx[6:0], i_miso};
  assign o_mosi     = r_sr[SPI_FRAME_BITS-1];
  assign o_sck      = r_sck;
  // Setup cycle, then phase 0 (sck low) / phase 1 (sck high); the edge ending phase 1 samples miso and shifts
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sr    <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_rx    <= '0;
      r_run   <= 1'b0;
      r_setup <= 1'b0;
      r_ph    <= 1'b0;
      r_sck   <= 1'b0;
    end else if (i_load) begin
      r_sr    <= i_frame;
      r_len   <= i_len;
      r_cnt   <= '0;
      r_run   <= 1'b1;
      r_setup <= 1'b1;
      r_ph    <= 1'b0;
      r_sck   <= 1'b0;
    end else if (r_run) begin
      if (r_setup) begin
        r_setup <= 1'b0;
      end else if (!r_ph) begin
        r_ph  <= 1'b1;
        r_sck <= 1'b1;
      end else begin
        r_ph  <= 1'b0;
        r_sck <= 1'b0;
        r_rx  <= o_rx;
        r_sr  <= {r_sr[SPI_FRAME_BITS-2:0], 1'b0};
        r_cnt <= r_cnt + 6'd1;
        r_run <= ~o_last_bit;
      end
    end
  end
endmodule

// File: rtl/spi_mem_ctrl.sv
// spi_mem_ctrl: control-unit memory stage driving a mode-0 SPI SRAM with a 4-phase done handshake (optional SPI_MEM_FAST_READ_EN)
module spi_mem_ctrl
  import spi_mem_ctrl_pkg::*;
#(
  parameter int DATA_BUS_WIDTH = 8,
  parameter int ADDR_WIDTH     = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [1:0]                i_mem_ctrl_op,
  input  logic [ADDR_WIDTH-1:0]     i_addr,
  input  logic [DATA_BUS_WIDTH-1:0] i_data_in,
  output logic [DATA_BUS_WIDTH-1:0] o_data_out,
  output logic                      o_mem_op_done,
  output logic                      o_busy,
  output logic                      o_spi_sck,
  output logic                      o_spi_cs_n,
  output logic                      o_spi_mosi,
  input  logic                      i_spi_miso
);
  spi_mem_state_e            r_state;
  logic                      r_rd;
  logic                      r_cs_n;
  logic                      r_busy;
  logic                      r_done;
  logic [DATA_BUS_WIDTH-1:0] r_data_out;
  logic                      w_is_rd;
  logic                      w_is_wr;
  logic                      w_load;
  logic                      w_last;
  logic [7:0]                w_rx;
  assign w_is_rd       = i_mem_ctrl_op == MEM_READ;
  assign w_is_wr       = i_mem_ctrl_op == MEM_WRITE;
  assign w_load        = (r_state == IDLE) & (w_is_rd | w_is_wr);
  assign o_data_out    = r_data_out;
  assign o_mem_op_done = r_done;
  assign o_busy        = r_busy;
  assign o_spi_cs_n    = r_cs_n;
  spi_mem_ctrl_shift u_shift (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_load),
    .i_frame    (build_frame(w_is_rd, i_addr, i_data_in)),
    .i_len      (w_is_rd ? SPI_LEN_READ : SPI_LEN_WRITE),
    .i_miso     (i_spi_miso),
    .o_last_bit (w_last),
    .o_sck      (o_spi_sck),
    .o_mosi     (o_spi_mosi),
    .o_rx       (w_rx)
  );
  // Transaction FSM; DONE holds until the op returns to NOP (undefined op codes count as NOP)
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_rd       <= 1'b0;
      r_cs_n     <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_data_out <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_load) begin
          r_state <= SHIFT;
          r_rd    <= w_is_rd;
          r_cs_n  <= 1'b0;
          r_busy  <= 1'b1;
        end
        SHIFT: if (w_last) begin
          r_state <= DONE;
          r_cs_n  <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          if (r_rd) r_data_out <= w_rx;
        end
        DONE: if (!w_is_rd && !w_is_wr) begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
